// File: rtl/dma_ahb_chan_arb_pkg.sv
// ----------------------------------------------------------------------------
// dma_ahb_chan_arb_pkg
// Shared definitions for the multi-channel DMA arbiter front end:
//   - arb_state_t : arbiter FSM state encoding
//   - BURST_*     : legal burst-length codes (1/4/8/16 beats)
//   - *_W         : descriptor field widths (src/dst/bnum/burst) and
//                   timeout counter width
// ----------------------------------------------------------------------------
package dma_ahb_chan_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_GO    = 3'd2,
    S_RUN   = 3'd3,
    S_ACK   = 3'd4,
    S_ERR   = 3'd5
  } arb_state_t;

  localparam logic [4:0] BURST_1  = 5'd1;
  localparam logic [4:0] BURST_4  = 5'd4;
  localparam logic [4:0] BURST_8  = 5'd8;
  localparam logic [4:0] BURST_16 = 5'd16;

  localparam int ADDR_W  = 32;
  localparam int BNUM_W  = 16;
  localparam int BURST_W = 5;
  localparam int CNT_W   = 8;

endpackage

// File: rtl/dma_ahb_rr_pick.sv
// ----------------------------------------------------------------------------
// dma_ahb_rr_pick
// Combinational round-robin picker. Searches REQ starting at PTR+1 and
// wrapping modulo NUM_CH; the first set bit wins.
//   NUM_CH : number of requesters
//   PW     : pointer width
//   REQ    : in  [NUM_CH]  request vector
//   PTR    : in  [PW]      index of the previous winner
//   WIN    : out [NUM_CH]  one-hot winner (0 when no request)
//   VALID  : out           at least one request present
// ----------------------------------------------------------------------------
module dma_ahb_rr_pick #(
  parameter int NUM_CH = 4,
  parameter int PW     = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] REQ,
  input  logic [PW-1:0]     PTR,
  output logic [NUM_CH-1:0] WIN,
  output logic              VALID
);

  logic [PW-1:0] idx;
  logic          found;

  // Offsets 1..NUM_CH so the previous winner is considered last.
  always_comb begin
    WIN   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = PW'((int'(PTR) + k) % NUM_CH);
      if (!found && REQ[idx]) begin
        WIN[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign VALID = |REQ;

endmodule

// File: rtl/dma_ahb_chan_arb.sv
// ----------------------------------------------------------------------------
// dma_ahb_chan_arb
// Multi-channel front end for the single-channel AHB DMA engine. Grants the
// engine to one requesting channel at a time (round robin), latches that
// channel's descriptor onto the engine inputs, follows DMA_BUSY/DMA_DONE and
// returns a one-cycle ACK (done) or ERR (timeout) pulse to the granted channel.
//   HCLK, HRESET : clock, synchronous active-high reset
//   EN           : global enable; gates new grants only
//   CH_REQ       : per-channel request levels
//   CH_SRC/DST   : packed 32-bit addresses, channel i at [32i+31:32i]
//   CH_BNUM      : packed 16-bit byte counts
//   CH_BURST     : packed 5-bit burst lengths
//   CH_GRANT     : one-hot active channel
//   CH_ACK/ERR   : one-cycle completion / timeout pulses
//   DMA_EN       : registered EN
//   DMA_GO       : engine start level
//   DMA_BUSY/DONE: engine status
//   DMA_SRC/DST/BNUM/BURST : latched descriptor of the granted channel
// ----------------------------------------------------------------------------
module dma_ahb_chan_arb
  import dma_ahb_chan_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int TO_CYC = 255
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      EN,
  input  logic [NUM_CH-1:0]         CH_REQ,
  input  logic [NUM_CH*ADDR_W-1:0]  CH_SRC,
  input  logic [NUM_CH*ADDR_W-1:0]  CH_DST,
  input  logic [NUM_CH*BNUM_W-1:0]  CH_BNUM,
  input  logic [NUM_CH*BURST_W-1:0] CH_BURST,
  output logic [NUM_CH-1:0]         CH_GRANT,
  output logic [NUM_CH-1:0]         CH_ACK,
  output logic [NUM_CH-1:0]         CH_ERR,
  output logic                      DMA_EN,
  output logic                      DMA_GO,
  input  logic                      DMA_BUSY,
  input  logic                      DMA_DONE,
  output logic [ADDR_W-1:0]         DMA_SRC,
  output logic [ADDR_W-1:0]         DMA_DST,
  output logic [BNUM_W-1:0]         DMA_BNUM,
  output logic [BURST_W-1:0]        DMA_BURST
);

  localparam int              PW     = $clog2(NUM_CH);
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TO_CYC);

  arb_state_t       state_reg;
  logic [PW-1:0]    ptr_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_inc;

  logic [NUM_CH-1:0] pick_win;
  logic              pick_valid;
  logic [PW-1:0]     win_idx;

  logic [ADDR_W-1:0]  src_arr   [NUM_CH];
  logic [ADDR_W-1:0]  dst_arr   [NUM_CH];
  logic [BNUM_W-1:0]  bnum_arr  [NUM_CH];
  logic [BURST_W-1:0] burst_arr [NUM_CH];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign src_arr[gi]   = CH_SRC[ADDR_W*gi +: ADDR_W];
      assign dst_arr[gi]   = CH_DST[ADDR_W*gi +: ADDR_W];
      assign bnum_arr[gi]  = CH_BNUM[BNUM_W*gi +: BNUM_W];
      assign burst_arr[gi] = CH_BURST[BURST_W*gi +: BURST_W];
    end
  endgenerate

  dma_ahb_rr_pick #(
    .NUM_CH (NUM_CH),
    .PW     (PW)
  ) u_pick (
    .REQ   (CH_REQ),
    .PTR   (ptr_reg),
    .WIN   (pick_win),
    .VALID (pick_valid)
  );

  // One-hot winner to index, used both for the descriptor mux and the pointer.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pick_win[i]) win_idx = PW'(i);
    end
  end

  assign cnt_inc = cnt_reg + CNT_W'(1);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_reg <= S_IDLE;
      ptr_reg   <= PW'(NUM_CH - 1);
      cnt_reg   <= '0;
      CH_GRANT  <= '0;
      CH_ACK    <= '0;
      CH_ERR    <= '0;
      DMA_EN    <= 1'b0;
      DMA_GO    <= 1'b0;
      DMA_SRC   <= '0;
      DMA_DST   <= '0;
      DMA_BNUM  <= '0;
      DMA_BURST <= '0;
    end else begin
      DMA_EN <= EN;
      CH_ACK <= '0;
      CH_ERR <= '0;
      case (state_reg)
        S_IDLE: begin
          if (EN && pick_valid) begin
            DMA_SRC   <= src_arr[win_idx];
            DMA_DST   <= dst_arr[win_idx];
            DMA_BNUM  <= bnum_arr[win_idx];
            DMA_BURST <= burst_arr[win_idx];
            CH_GRANT  <= pick_win;
            ptr_reg   <= win_idx;
            state_reg <= S_SETUP;
          end
        end
        S_SETUP: begin
          // Zero-length descriptors complete without ever starting the engine.
          if (DMA_BNUM == '0) begin
            state_reg <= S_ACK;
          end else begin
            DMA_GO    <= 1'b1;
            cnt_reg   <= '0;
            state_reg <= S_GO;
          end
        end
        S_GO: begin
          if (DMA_DONE) begin
            state_reg <= S_ACK;
          end else if (DMA_BUSY) begin
            state_reg <= S_RUN;
          end else begin
            cnt_reg <= cnt_inc;
            if (cnt_inc == TO_LIM) state_reg <= S_ERR;
          end
        end
        S_RUN: begin
          // Only idle (not busy, not done) cycles count toward the timeout.
          if (DMA_DONE) begin
            state_reg <= S_ACK;
          end else if (!DMA_BUSY) begin
            cnt_reg <= cnt_inc;
            if (cnt_inc == TO_LIM) state_reg <= S_ERR;
          end
        end
        S_ACK: begin
          DMA_GO    <= 1'b0;
          CH_ACK    <= CH_GRANT;
          CH_GRANT  <= '0;
          state_reg <= S_IDLE;
        end
        S_ERR: begin
          DMA_GO    <= 1'b0;
          CH_ERR    <= CH_GRANT;
          CH_GRANT  <= '0;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_ahb_chan_arb.sv
// ----------------------------------------------------------------------------
// tb_dma_ahb_chan_arb
// Directed bench with a scoreboard: stimulus pushes the expected grant
// (channel + descriptor) and expected completion (ACK/ERR) records; a monitor
// running on the falling edge pops and compares whenever a new grant appears
// or a completion pulse is seen. Cycle-exact timing points are checked inline.
// ----------------------------------------------------------------------------
module tb_dma_ahb_chan_arb;

  localparam int NCH = 4;

  typedef struct packed {
    logic [3:0]  grant;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] bnum;
    logic [4:0]  burst;
  } gexp_t;

  typedef struct packed {
    logic [3:0] ack;
    logic [3:0] err;
  } dexp_t;

  logic              HCLK;
  logic              HRESET;
  logic              EN;
  logic [NCH-1:0]    CH_REQ;
  logic [NCH*32-1:0] CH_SRC;
  logic [NCH*32-1:0] CH_DST;
  logic [NCH*16-1:0] CH_BNUM;
  logic [NCH*5-1:0]  CH_BURST;
  logic [NCH-1:0]    CH_GRANT;
  logic [NCH-1:0]    CH_ACK;
  logic [NCH-1:0]    CH_ERR;
  logic              DMA_EN;
  logic              DMA_GO;
  logic              DMA_BUSY;
  logic              DMA_DONE;
  logic [31:0]       DMA_SRC;
  logic [31:0]       DMA_DST;
  logic [15:0]       DMA_BNUM;
  logic [4:0]        DMA_BURST;

  int checks   = 0;
  int failures = 0;

  gexp_t grant_q[$];
  dexp_t done_q[$];

  dma_ahb_chan_arb #(
    .NUM_CH (NCH),
    .TO_CYC (8)
  ) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .EN        (EN),
    .CH_REQ    (CH_REQ),
    .CH_SRC    (CH_SRC),
    .CH_DST    (CH_DST),
    .CH_BNUM   (CH_BNUM),
    .CH_BURST  (CH_BURST),
    .CH_GRANT  (CH_GRANT),
    .CH_ACK    (CH_ACK),
    .CH_ERR    (CH_ERR),
    .DMA_EN    (DMA_EN),
    .DMA_GO    (DMA_GO),
    .DMA_BUSY  (DMA_BUSY),
    .DMA_DONE  (DMA_DONE),
    .DMA_SRC   (DMA_SRC),
    .DMA_DST   (DMA_DST),
    .DMA_BNUM  (DMA_BNUM),
    .DMA_BURST (DMA_BURST)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end else begin
      $display("ok   %s = %0h", nm, act);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic set_desc(input int ch, input logic [31:0] s, input logic [31:0] d,
                          input logic [15:0] b, input logic [4:0] u);
    CH_SRC[32*ch +: 32]  = s;
    CH_DST[32*ch +: 32]  = d;
    CH_BNUM[16*ch +: 16] = b;
    CH_BURST[5*ch +: 5]  = u;
  endtask

  task automatic push_grant(input logic [3:0] g, input logic [31:0] s, input logic [31:0] d,
                            input logic [15:0] b, input logic [4:0] u);
    gexp_t e;
    e.grant = g; e.src = s; e.dst = d; e.bnum = b; e.burst = u;
    grant_q.push_back(e);
  endtask

  task automatic push_done(input logic [3:0] a, input logic [3:0] e);
    dexp_t r;
    r.ack = a; r.err = e;
    done_q.push_back(r);
  endtask

  // Called just after the grant edge: GO rises, engine busy for busy_cyc
  // cycles, DONE for one cycle, then returns just after the ACK edge.
  task automatic serve(input int busy_cyc);
    tick();
    DMA_BUSY = 1'b1;
    repeat (busy_cyc) tick();
    DMA_BUSY = 1'b0;
    DMA_DONE = 1'b1;
    tick();
    DMA_DONE = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    tick();
    tick();
    chk("rst_grant", {124'd0, CH_GRANT}, 128'd0);
    chk("rst_ack_err", {120'd0, CH_ACK, CH_ERR}, 128'd0);
    chk("rst_en_go", {126'd0, DMA_EN, DMA_GO}, 128'd0);
    chk("rst_desc", {43'd0, DMA_SRC, DMA_DST, DMA_BNUM, DMA_BURST}, 128'd0);
    HRESET = 1'b0;
  endtask

  // Scoreboard monitor
  initial begin
    logic [3:0] prev_grant;
    gexp_t g;
    dexp_t d;
    prev_grant = '0;
    forever begin
      @(negedge HCLK);
      if (!HRESET) begin
        if (prev_grant == 4'd0 && CH_GRANT != 4'd0) begin
          if (grant_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL sb_grant unexpected grant actual=%0h expected=none", CH_GRANT);
          end else begin
            g = grant_q.pop_front();
            chk("sb_grant", {39'd0, CH_GRANT, DMA_SRC, DMA_DST, DMA_BNUM, DMA_BURST}, {39'd0, g});
          end
        end
        if (CH_ACK != 4'd0 || CH_ERR != 4'd0) begin
          if (done_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL sb_done unexpected ack=%0h err=%0h expected=none", CH_ACK, CH_ERR);
          end else begin
            d = done_q.pop_front();
            chk("sb_done", {120'd0, CH_ACK, CH_ERR}, {120'd0, d});
          end
        end
      end
      prev_grant = CH_GRANT;
    end
  end

  // Stimulus
  initial begin
    logic [3:0] fair_order [5];
    logic       err_seen;
    fair_order[0] = 4'b0001; fair_order[1] = 4'b0010; fair_order[2] = 4'b0100;
    fair_order[3] = 4'b1000; fair_order[4] = 4'b0001;

    HRESET = 1'b1; EN = 1'b1; CH_REQ = '0; DMA_BUSY = 1'b0; DMA_DONE = 1'b0;
    CH_SRC = '0; CH_DST = '0; CH_BNUM = '0; CH_BURST = '0;
    do_reset();

    // ---- single channel ----
    set_desc(1, 32'h1000_0000, 32'h2000_0000, 16'd64, 5'd4);
    push_grant(4'b0010, 32'h1000_0000, 32'h2000_0000, 16'd64, 5'd4);
    push_done(4'b0010, 4'b0000);
    CH_REQ = 4'b0010;
    tick();
    chk("t1_grant", {124'd0, CH_GRANT}, {124'd0, 4'b0010});
    chk("t1_go_low", {127'd0, DMA_GO}, 128'd0);
    CH_REQ = 4'b0000;
    set_desc(1, 32'hDEAD_BEEF, 32'hFEED_F00D, 16'd7, 5'd1);
    tick();
    chk("t1_go_high", {127'd0, DMA_GO}, 128'd1);
    DMA_BUSY = 1'b1;
    tick();
    tick();
    DMA_BUSY = 1'b0; DMA_DONE = 1'b1;
    tick();
    DMA_DONE = 1'b0;
    chk("t1_ack_early", {124'd0, CH_ACK}, 128'd0);
    tick();
    chk("t1_ack", {124'd0, CH_ACK}, {124'd0, 4'b0010});
    chk("t1_go_drop", {127'd0, DMA_GO}, 128'd0);
    chk("t1_grant_clr", {124'd0, CH_GRANT}, 128'd0);
    chk("t1_src_held", {96'd0, DMA_SRC}, {96'd0, 32'h1000_0000});
    tick();
    chk("t1_ack_pulse", {124'd0, CH_ACK}, 128'd0);

    // ---- fairness ----
    do_reset();
    set_desc(0, 32'hA000_0000, 32'hB000_0000, 16'd16,  5'd1);
    set_desc(1, 32'hA000_0100, 32'hB000_0100, 16'd32,  5'd4);
    set_desc(2, 32'hA000_0200, 32'hB000_0200, 16'd48,  5'd8);
    set_desc(3, 32'hA000_0300, 32'hB000_0300, 16'd256, 5'd16);
    push_grant(4'b0001, 32'hA000_0000, 32'hB000_0000, 16'd16,  5'd1);
    push_grant(4'b0010, 32'hA000_0100, 32'hB000_0100, 16'd32,  5'd4);
    push_grant(4'b0100, 32'hA000_0200, 32'hB000_0200, 16'd48,  5'd8);
    push_grant(4'b1000, 32'hA000_0300, 32'hB000_0300, 16'd256, 5'd16);
    push_grant(4'b0001, 32'hA000_0000, 32'hB000_0000, 16'd16,  5'd1);
    push_done(4'b0001, 4'b0000);
    push_done(4'b0010, 4'b0000);
    push_done(4'b0100, 4'b0000);
    push_done(4'b1000, 4'b0000);
    push_done(4'b0001, 4'b0000);
    CH_REQ = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("fair_grant", {124'd0, CH_GRANT}, {124'd0, fair_order[i]});
      if (i == 4) CH_REQ = 4'b0000;
      serve(i % 2);
    end
    tick();
    chk("fair_idle", {124'd0, CH_GRANT}, 128'd0);

    // ---- zero length ----
    set_desc(2, 32'h3000_0000, 32'h4000_0000, 16'd0, 5'd8);
    push_grant(4'b0100, 32'h3000_0000, 32'h4000_0000, 16'd0, 5'd8);
    push_done(4'b0100, 4'b0000);
    CH_REQ = 4'b0100;
    tick();
    chk("z_grant", {124'd0, CH_GRANT}, {124'd0, 4'b0100});
    CH_REQ = 4'b0000;
    tick();
    chk("z_go_setup", {123'd0, DMA_GO, CH_ACK}, 128'd0);
    tick();
    chk("z_ack", {123'd0, DMA_GO, CH_ACK}, {123'd0, 1'b0, 4'b0100});
    tick();
    chk("z_ack_pulse", {123'd0, DMA_GO, CH_ACK}, 128'd0);

    // ---- timeout (TO_CYC = 8) ----
    set_desc(3, 32'h5000_0000, 32'h6000_0000, 16'd128, 5'd16);
    push_grant(4'b1000, 32'h5000_0000, 32'h6000_0000, 16'd128, 5'd16);
    push_done(4'b0000, 4'b1000);
    CH_REQ = 4'b1000;
    tick();
    CH_REQ = 4'b0000;
    tick();
    chk("to_go_high", {127'd0, DMA_GO}, 128'd1);
    err_seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (CH_ERR != 4'd0) err_seen = 1'b1;
    end
    chk("to_err_early", {127'd0, err_seen}, 128'd0);
    tick();
    chk("to_err", {119'd0, DMA_GO, CH_ERR, CH_GRANT}, {119'd0, 1'b0, 4'b1000, 4'b0000});
    tick();
    chk("to_err_pulse", {124'd0, CH_ERR}, 128'd0);

    // ---- EN gating ----
    EN = 1'b0;
    set_desc(0, 32'h7000_0000, 32'h8000_0000, 16'd8, 5'd1);
    CH_REQ = 4'b0001;
    tick();
    chk("en_dma_en_low", {127'd0, DMA_EN}, 128'd0);
    tick();
    tick();
    chk("en_no_grant", {124'd0, CH_GRANT}, 128'd0);
    push_grant(4'b0001, 32'h7000_0000, 32'h8000_0000, 16'd8, 5'd1);
    push_done(4'b0001, 4'b0000);
    EN = 1'b1;
    tick();
    chk("en_grant", {124'd0, CH_GRANT}, {124'd0, 4'b0001});
    CH_REQ = 4'b0000;
    EN = 1'b0;
    serve(2);
    chk("en_off_ack", {124'd0, CH_ACK}, {124'd0, 4'b0001});
    chk("en_off_dma_en", {127'd0, DMA_EN}, 128'd0);
    EN = 1'b1;
    tick();

    // ---- reset during RUN ----
    set_desc(0, 32'h9000_0000, 32'h9100_0000, 16'd4, 5'd4);
    push_grant(4'b0001, 32'h9000_0000, 32'h9100_0000, 16'd4, 5'd4);
    CH_REQ = 4'b0001;
    tick();
    CH_REQ = 4'b0000;
    tick();
    DMA_BUSY = 1'b1;
    tick();
    HRESET = 1'b1;
    tick();
    chk("rr_abort", {115'd0, DMA_GO, CH_GRANT, CH_ACK, CH_ERR}, 128'd0);
    HRESET = 1'b0;
    DMA_BUSY = 1'b0;
    set_desc(1, 32'hC000_0000, 32'hD000_0000, 16'd12, 5'd8);
    push_grant(4'b0001, 32'h9000_0000, 32'h9100_0000, 16'd4, 5'd4);
    push_done(4'b0001, 4'b0000);
    CH_REQ = 4'b0011;
    tick();
    chk("rr_ch0_wins", {124'd0, CH_GRANT}, {124'd0, 4'b0001});
    CH_REQ = 4'b0000;
    serve(0);
    chk("rr_ack", {124'd0, CH_ACK}, {124'd0, 4'b0001});
    tick();
    tick();

    chk("sb_grant_q_empty", 128'(grant_q.size()), 128'd0);
    chk("sb_done_q_empty", 128'(done_q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
